// File: rtl/dot_product_accumulator.sv
// Sums every VEC_LEN accepted unsigned products into one saturating dot-product result,
// presented on a valid/ready output register. in_ready also freezes the upstream multiplier.
module dot_product_accumulator #(
    parameter int WIDTH     = 8,
    parameter int VEC_LEN   = 16,
    parameter int ACC_WIDTH = 2*WIDTH+4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [2*WIDTH-1:0]   in_product,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] count
);

    // state | meaning
    // ACCUM | no result pending; products accumulate freely
    // HOLD  | result presented, waiting for out_ready
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} mode_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VEC_LEN-1);

    mode_t                state, state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic                 sat;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] next_acc;
    logic                 next_sat;
    logic                 accept;
    logic                 final_accept;
    logic                 take;

    // One extra bit catches the carry; a carry pins the sum at all-ones.
    assign sum_wide     = {1'b0, acc} + (ACC_WIDTH+1)'(in_product);
    assign next_acc     = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
    assign next_sat     = sat | sum_wide[ACC_WIDTH];
    assign accept       = in_valid && in_ready;
    assign final_accept = accept && (count == LAST);
    assign take         = (state == HOLD) && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (final_accept) begin
            state_next = HOLD;
        end else if (take) begin
            state_next = ACCUM;
        end
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = !clear && ((state == ACCUM) || out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            sat          <= 1'b0;
            count        <= '0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            sat   <= 1'b0;
            count <= '0;
        end else if (final_accept) begin
            out_sum      <= next_acc;
            out_overflow <= next_sat;
            acc          <= '0;
            sat          <= 1'b0;
            count        <= '0;
        end else if (accept) begin
            acc   <= next_acc;
            sat   <= next_sat;
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: a vector-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_dot_product_accumulator;

    localparam int W  = 8;
    localparam int VL = 4;
    localparam int AW = 16;
    localparam int CW = 4;
    localparam longint MAXV = (64'd1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [2*W-1:0] in_product;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] out_sum;
    logic          out_overflow;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference: running integer total of the vector; the result is the total clipped to the
    // accumulator range, flagged when the clip took effect.
    longint m_total = 0;
    int     m_cnt   = 0;
    bit     m_valid = 1'b0;
    longint m_sum   = 0;
    bit     m_ovf   = 1'b0;
    bit     m_rdy;
    bit     m_acc;

    dot_product_accumulator #(
        .WIDTH(W), .VEC_LEN(VL), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_product(in_product), .in_valid(in_valid), .in_ready(in_ready),
        .out_sum(out_sum), .out_overflow(out_overflow), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_total = 0; m_cnt = 0; m_valid = 1'b0; m_sum = 0; m_ovf = 1'b0;
        end else begin
            m_rdy = !clear && (!m_valid || out_ready);
            m_acc = in_valid && m_rdy;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_acc) begin
                m_total += longint'(in_product);
                m_cnt++;
                if (m_cnt == VL) begin
                    m_sum   = (m_total > MAXV) ? MAXV : m_total;
                    m_ovf   = (m_total > MAXV);
                    m_valid = 1'b1;
                    m_total = 0;
                    m_cnt   = 0;
                end
            end else if (clear) begin
                m_total = 0;
                m_cnt   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_out_valid", out_valid, m_valid);
            chk("m_count", count, m_cnt);
            chk("m_in_ready", in_ready, !clear && (!m_valid || out_ready));
            if (m_valid) begin
                chk("m_out_sum", out_sum, m_sum);
                chk("m_out_overflow", out_overflow, m_ovf);
            end
        end
    end

    task automatic cyc(input bit v, input int p, input bit ordy, input bit clr);
        in_valid   = v;
        in_product = p[2*W-1:0];
        out_ready  = ordy;
        clear      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", out_overflow, 0);
        cmp_en = 1'b1;
        reset  = 1'b1;
        idle();

        // 1,2,3,4 -> 10
        cyc(1, 1, 1, 0); chk("s1_cnt1", count, 1);
        cyc(1, 2, 1, 0); chk("s1_cnt2", count, 2);
        cyc(1, 3, 1, 0); chk("s1_cnt3", count, 3);
        cyc(1, 4, 1, 0);
        chk("s1_valid", out_valid, 1);
        chk("s1_sum", out_sum, 10);
        chk("s1_ovf", out_overflow, 0);
        chk("s1_cnt0", count, 0);
        idle();
        chk("s1_valid_drop", out_valid, 0);

        // back-to-back vectors 4 then 8
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
        chk("s2_sum4", out_sum, 4);
        chk("s2_valid4", out_valid, 1);
        for (int i = 0; i < 4; i++) cyc(1, 2, 1, 0);
        chk("s2_sum8", out_sum, 8);
        chk("s2_valid8", out_valid, 1);
        idle();

        // backpressure: 20 held, 7 waits, then accepted exactly once
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
        chk("s3_sum20", out_sum, 20);
        chk("s3_in_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) cyc(1, 7, 0, 0);
        chk("s3_cnt_stall", count, 0);
        chk("s3_sum_held", out_sum, 20);
        chk("s3_valid_held", out_valid, 1);
        cyc(1, 7, 1, 0);
        chk("s3_cnt1", count, 1);
        chk("s3_taken", out_valid, 0);
        idle();
        chk("s3_cnt1_hold", count, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
        chk("s3_sum7", out_sum, 7);
        idle();

        // saturation then recovery
        for (int i = 0; i < 4; i++) cyc(1, 65025, 1, 0);
        chk("s4_sat_sum", out_sum, 16'hFFFF);
        chk("s4_sat_ovf", out_overflow, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
        chk("s4_sum4", out_sum, 4);
        chk("s4_ovf0", out_overflow, 0);
        idle();

        // clear mid-vector
        cyc(1, 9, 1, 0);
        cyc(1, 9, 1, 0);
        chk("s5_cnt2", count, 2);
        cyc(1, 9, 1, 1);
        chk("s5_cleared", count, 0);
        for (int i = 0; i < 4; i++) cyc(1, 3, 1, 0);
        chk("s5_sum12", out_sum, 12);
        idle();

        // reset mid-vector
        cyc(1, 2, 1, 0);
        cyc(1, 2, 1, 0);
        chk("s6_cnt2", count, 2);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk("s6_rst_cnt", count, 0);
        @(posedge clk); #1 reset = 1'b1;
        idle();

        // reset with an unread result held
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        chk("s6_held_valid", out_valid, 1);
        chk("s6_held_sum", out_sum, 4);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_valid", out_valid, 0);
        chk("s6_rst_sum", out_sum, 0);
        chk("s6_rst_cnt0", count, 0);
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, 2, 1, 0);
        chk("s6_sum8", out_sum, 8);
        chk("s6_valid8", out_valid, 1);
        idle();
        idle();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Downstream stage of the pipelined multiplier. Consumes its unsigned product stream and sums every VEC_LEN consecutive accepted products into one dot-product result.
- Presents each result on a valid/ready output register.
- Exports in_ready. The upstream wrapper drives the multiplier's enable with it, so the whole multiply pipeline freezes under backpressure and no product is lost or duplicated.

Parameters:
- WIDTH, 8: multiplier operand width. Product width is 2*WIDTH.
- VEC_LEN, 16: products per dot product. Must be ≥2.
- ACC_WIDTH, 2*WIDTH+4: accumulator and result width. Must be ≥ 2*WIDTH.
- CNT_WIDTH, 4: element counter width. Must hold VEC_LEN-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous. Discards the partial accumulation.
- in_product  in  2*WIDTH  unsigned product from the multiplier.
- in_valid  in  1  in_product is valid.
- in_ready  out  1  block accepts in_product this cycle. Also gates the multiplier enable.
- out_sum  out  ACC_WIDTH  completed dot product.
- out_overflow  out  1  saturation occurred in this result's vector.
- out_valid  out  1  out_sum and out_overflow are valid.
- out_ready  in  1  consumer takes the result this cycle.
- count  out  CNT_WIDTH  products accepted so far in the current vector.

Behaviour:
- Reset (reset=0):
  - Takes effect immediately, without waiting for a clock edge.
  - Clears acc, count, sat flag, out_sum, out_overflow and out_valid to 0.
  - Mid-vector reset drops the partial sum. Normal operation resumes on the first edge after reset=1.
- in_ready (combinational) = !clear && (!out_valid || out_ready).
- Accept: on a rising edge where in_valid && in_ready.
- Internal state:
  - acc (ACC_WIDTH), count, sat (sticky flag for the current vector).
  - Mode derived from state: ACCUM (out_valid=0), HOLD (out_valid=1, waiting on out_ready).
- Arithmetic:
  - next = acc + zero-extended in_product, computed one bit wider.
  - If the carry bit is set: next saturates to all-ones and sat_next=1. Otherwise sat_next=sat.
- Non-final accept (count < VEC_LEN-1): acc<=next, sat<=sat_next, count<=count+1.
- Final accept (count == VEC_LEN-1):
  - out_sum<=next, out_overflow<=sat_next, out_valid<=1.
  - acc<=0, sat<=0, count<=0.
  - Latency: result is visible right after the edge that accepts the last product.
- Output handshake:
  - out_valid && out_ready at an edge with no final accept: out_valid<=0.
  - Same edge as a final accept: the new result replaces the old one and out_valid stays 1. This supports back-to-back vectors at full rate.
- Backpressure:
  - While out_valid && !out_ready, in_ready=0. Accumulation stalls even mid-next-vector.
  - out_sum and out_overflow hold stable until taken.
- clear=1 at an edge:
  - acc<=0, sat<=0, count<=0.
  - in_ready=0, so no product is accepted that cycle.
  - The held result (out_valid, out_sum, out_overflow) is unaffected and still follows out_ready.
- in_valid=0 gaps: state holds. Gaps of any length are legal.
- Products accepted while in_ready=0: none. in_product is ignored.
- With the default ACC_WIDTH and VEC_LEN, overflow is impossible. Saturation only occurs with a narrower ACC_WIDTH.

Test Plan:
- WIDTH=8, VEC_LEN=4, out_ready=1: accept 1,2,3,4 back-to-back -> out_valid=1 for exactly one cycle after the 4th accept, out_sum=10, out_overflow=0, in_ready constantly 1. count steps 0,1,2,3,0.
- Back-to-back vectors 1,1,1,1 then 2,2,2,2 with out_ready=1 -> results 4 then 8 on consecutive final-accept edges, no idle cycle.
- Backpressure:
  - Vector 5,5,5,5 completes with out_ready=0 -> out_sum=20 held, in_ready=0. Upstream product 7 held for 3 cycles is not accepted.
  - Raise out_ready -> 20 taken, then 7 accepted exactly once (count=1).
- VEC_LEN=4, ACC_WIDTH=16: products 65025 x4 -> out_sum=0xFFFF, out_overflow=1. Next vector 1,1,1,1 -> out_sum=4, out_overflow=0.
- Accept 9,9 (count=2), pulse clear with in_valid=1 -> no accept that cycle, count=0. Then 3,3,3,3 -> out_sum=12.
- Reset mid-operation:
  - After 2 accepts plus a held unread result, drop reset between edges -> out_valid, out_sum and count read 0 before the next edge.
  - After release, 2,2,2,2 -> out_sum=8.
